// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared definitions for the memory-stage SRAM controller: FSM states, default
// base address and external SRAM data width.
package mem_stage_sram_ctrl_pkg;

    localparam int unsigned BASE_ADDR_DEF = 1024;
    localparam int unsigned SRAM_DW       = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mem_stage_sram_ctrl_phase_counter.sv
// Per-phase wait counter: counts 0..WAIT_CYCLES-1, clears on request and
// flags the final cycle of the phase.
module sram_phase_counter #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned CW          = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    output logic [CW-1:0] count,
    output logic          last
);

    assign last = (count == CW'(WAIT_CYCLES - 1));

    // Wrapping on last makes the next phase start at 0 without an explicit clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || last) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage responder: splits each 32-bit load/store into two 16-bit
// asynchronous SRAM phases and holds ready low until the access completes.
module mem_stage_sram_ctrl
    import mem_stage_sram_ctrl_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = BASE_ADDR_DEF,
    parameter int unsigned SRAM_ADDR_W = 18,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_r_en,
    input  logic                   mem_w_en,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    inout  wire  [SRAM_DW-1:0]     sram_dq,
    output logic                   sram_we_n
);

    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] PENULT = CW'(WAIT_CYCLES - 2);

    state_t                 state;
    logic                   req;
    logic                   is_write;
    logic [SRAM_ADDR_W-2:0] idx;
    logic [SRAM_ADDR_W-2:0] req_idx;
    logic [31:0]            wdata_q;
    logic [SRAM_DW-1:0]     dout;
    logic                   drive;
    logic [CW-1:0]          count;
    logic                   last;

    assign req     = mem_r_en | mem_w_en;
    assign req_idx = (SRAM_ADDR_W-1)'((addr - 32'(BASE_ADDR)) >> 2);
    assign ready   = ((state == ST_IDLE) && !req) || (state == ST_DONE);
    assign sram_dq = drive ? dout : 16'bz;

    sram_phase_counter #(
        .WAIT_CYCLES(WAIT_CYCLES),
        .CW         (CW)
    ) u_phase_counter (
        .clk  (clk),
        .rst  (rst),
        .clear((state != ST_LOW) && (state != ST_HIGH)),
        .count(count),
        .last (last)
    );

    // Bus outputs are set up one edge ahead so addr/data are stable for the
    // whole phase and we_n rises one cycle before the phase ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            is_write  <= 1'b0;
            idx       <= '0;
            wdata_q   <= '0;
            rdata     <= '0;
            sram_addr <= '0;
            sram_we_n <= 1'b1;
            dout      <= '0;
            drive     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        state     <= ST_LOW;
                        is_write  <= mem_w_en;
                        idx       <= req_idx;
                        wdata_q   <= wdata;
                        sram_addr <= {req_idx, 1'b0};
                        sram_we_n <= ~mem_w_en;
                        drive     <= mem_w_en;
                        dout      <= wdata[15:0];
                    end
                end
                ST_LOW: begin
                    if (last) begin
                        state     <= ST_HIGH;
                        sram_addr <= {idx, 1'b1};
                        sram_we_n <= ~is_write;
                        dout      <= wdata_q[31:16];
                        if (!is_write) begin
                            rdata[15:0] <= sram_dq;
                        end
                    end else if (count == PENULT) begin
                        sram_we_n <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (last) begin
                        state     <= ST_DONE;
                        sram_we_n <= 1'b1;
                        drive     <= 1'b0;
                        if (!is_write) begin
                            rdata[31:16] <= sram_dq;
                        end
                    end else if (count == PENULT) begin
                        sram_we_n <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
